// File: rtl/bus_ram_responder_pkg.sv
// Shared definitions for the bus RAM responder.
// Holds the bus command and response encodings and the bus address width.
// The top level and its response FIFO import this package.
package bus_ram_responder_pkg;

    localparam int BUS_ADDR_W = 32;

    // Master command encodings carried on MCmd.
    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_WR   = 2'b01,
        CMD_RD   = 2'b10
    } mcmd_e;

    // Slave response encodings carried on SResp.
    typedef enum logic [1:0] {
        RESP_NULL = 2'b00,
        RESP_DVA  = 2'b01
    } sresp_e;

endpackage

// File: rtl/bus_ram_responder_resp_fifo.sv
// Response FIFO for the bus RAM responder.
// Holds read data that is waiting to be returned on the bus, in arrival order.
// Ports:
//   clk, reset  - clock; asynchronous active-high reset (empties the FIFO)
//   i_flush     - synchronous flush; empties the FIFO and wins over push
//   i_push      - write i_data_in at the tail (ignored when full)
//   i_pop       - drop the head entry (ignored when empty)
//   i_data_in   - entry to push
//   o_data_out  - current head entry, read straight from the storage registers
//   o_count     - number of valid entries
//   o_empty     - no valid entries
module bus_ram_responder_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data_in,
    output logic [WIDTH-1:0]         o_data_out,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop && (r_count != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    assign o_data_out = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/bus_ram_responder.sv
// Bus slave that serves cache line fetches and stores out of a synchronous
// single-port RAM. One command is accepted per cycle; reads return their data
// in accept order through a small response FIFO, writes are posted and
// produce no response.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   i_m_cmd           - MCmd (IDLE/RD/WR)
//   i_m_addr          - MAddr, word address; bits above MEM_ADDR_SIZE ignored
//   i_m_data          - MData, write data
//   i_m_byte_en       - MByteEn, write byte enables
//   i_m_resp_accept   - MRespAccept, master takes the current response
//   i_m_reset_n       - MReset_n, low flushes the responder synchronously
//   o_s_cmd_accept    - SCmdAccept, combinational accept of i_m_cmd
//   o_s_resp          - SResp (NULL/DVA), FIFO head valid
//   o_s_data          - SData, FIFO head data (zero when no response)
//   o_ram_en/we/be/addr/data_w - RAM request, driven in the accept cycle
//   i_ram_data_r      - RAM read data, valid the cycle after the read
//   i_ram_delay       - RAM stall: holds the capture and blocks new commands
// Handshake: a command transfers in a cycle where i_m_cmd != IDLE and
// o_s_cmd_accept is high; a response transfers in a cycle where
// o_s_resp == DVA and i_m_resp_accept is high.
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter int RESP_DEPTH    = 4,
    parameter int MEM_ADDR_SIZE = 12,
    parameter int WORD_SIZE     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 i_m_cmd,
    input  logic [BUS_ADDR_W-1:0]      i_m_addr,
    input  logic [WORD_SIZE-1:0]       i_m_data,
    input  logic [WORD_SIZE/8-1:0]     i_m_byte_en,
    input  logic                       i_m_resp_accept,
    input  logic                       i_m_reset_n,
    output logic                       o_s_cmd_accept,
    output logic [1:0]                 o_s_resp,
    output logic [WORD_SIZE-1:0]       o_s_data,
    output logic                       o_ram_en,
    output logic                       o_ram_we,
    output logic [WORD_SIZE/8-1:0]     o_ram_be,
    output logic [MEM_ADDR_SIZE-1:0]   o_ram_addr,
    output logic [WORD_SIZE-1:0]       o_ram_data_w,
    input  logic [WORD_SIZE-1:0]       i_ram_data_r,
    input  logic                       i_ram_delay
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RESP_DEPTH);

    logic                 r_pending;
    logic [CW-1:0]        w_count;
    logic [CW-1:0]        w_occ;
    logic                 w_empty;
    logic [WORD_SIZE-1:0] w_head;
    logic                 w_is_rd;
    logic                 w_is_wr;
    logic                 w_accept;
    logic                 w_accept_rd;
    logic                 w_accept_wr;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_unused_addr_hi;

    // Upper address bits alias onto the RAM.
    assign w_unused_addr_hi = ^i_m_addr[BUS_ADDR_W-1:MEM_ADDR_SIZE];

    assign w_is_rd = (i_m_cmd == CMD_RD);
    assign w_is_wr = (i_m_cmd == CMD_WR);

    // A read is admitted only if its response slot is guaranteed: the read
    // still in the RAM counts, a pop in this same cycle does not.
    assign w_occ = w_count + CW'(r_pending);

    assign w_accept = !reset && i_m_reset_n && !i_ram_delay &&
                      ((w_is_rd && (w_occ < DEPTH_CNT)) || w_is_wr);
    assign w_accept_rd = w_accept && w_is_rd;
    assign w_accept_wr = w_accept && w_is_wr;

    // The RAM output is valid in the first non-stalled cycle after the read.
    assign w_capture = r_pending && !i_ram_delay;
    assign w_pop     = !w_empty && i_m_resp_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (!i_m_reset_n) begin
            r_pending <= 1'b0;
        end else if (w_accept_rd) begin
            // A back-to-back read keeps the flag set while the previous
            // one is captured.
            r_pending <= 1'b1;
        end else if (w_capture) begin
            r_pending <= 1'b0;
        end
    end

    bus_ram_responder_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (WORD_SIZE)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (!i_m_reset_n),
        .i_push     (w_capture),
        .i_pop      (w_pop),
        .i_data_in  (i_ram_data_r),
        .o_data_out (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty)
    );

    always_comb begin
        o_ram_be = '0;
        if (w_accept_rd) begin
            o_ram_be = '1;
        end else if (w_accept_wr) begin
            o_ram_be = i_m_byte_en;
        end
    end

    assign o_s_cmd_accept = w_accept;
    assign o_ram_en       = w_accept;
    assign o_ram_we       = w_accept_wr;
    assign o_ram_addr     = i_m_addr[MEM_ADDR_SIZE-1:0];
    assign o_ram_data_w   = i_m_data;

    assign o_s_resp = w_empty ? RESP_NULL : RESP_DVA;
    assign o_s_data = w_empty ? '0 : w_head;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Testbench for bus_ram_responder: directed table, backpressure and reset
// sequences, then randomized traffic, all checked against a transaction-level
// reference model with a synchronous RAM model attached to the RAM port.
module tb_bus_ram_responder;
    import bus_ram_responder_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int W     = 32;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        racc;
        logic        dly;
        logic        mrn;
        logic        exp_acc;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    i_m_cmd;
    logic [31:0]   i_m_addr;
    logic [W-1:0]  i_m_data;
    logic [3:0]    i_m_byte_en;
    logic          i_m_resp_accept;
    logic          i_m_reset_n;
    logic          o_s_cmd_accept;
    logic [1:0]    o_s_resp;
    logic [W-1:0]  o_s_data;
    logic          o_ram_en;
    logic          o_ram_we;
    logic [3:0]    o_ram_be;
    logic [AW-1:0] o_ram_addr;
    logic [W-1:0]  o_ram_data_w;
    logic [W-1:0]  i_ram_data_r;
    logic          i_ram_delay;

    always #5 clk = ~clk;

    bus_ram_responder #(
        .RESP_DEPTH    (DEPTH),
        .MEM_ADDR_SIZE (AW),
        .WORD_SIZE     (W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_m_cmd         (i_m_cmd),
        .i_m_addr        (i_m_addr),
        .i_m_data        (i_m_data),
        .i_m_byte_en     (i_m_byte_en),
        .i_m_resp_accept (i_m_resp_accept),
        .i_m_reset_n     (i_m_reset_n),
        .o_s_cmd_accept  (o_s_cmd_accept),
        .o_s_resp        (o_s_resp),
        .o_s_data        (o_s_data),
        .o_ram_en        (o_ram_en),
        .o_ram_we        (o_ram_we),
        .o_ram_be        (o_ram_be),
        .o_ram_addr      (o_ram_addr),
        .o_ram_data_w    (o_ram_data_w),
        .i_ram_data_r    (i_ram_data_r),
        .i_ram_delay     (i_ram_delay)
    );

    // ---------------- synchronous RAM attached to the DUT ----------------
    logic [W-1:0] ram_mem [1<<AW];

    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (o_ram_be[b]) ram_mem[o_ram_addr][8*b +: 8] <= o_ram_data_w[8*b +: 8];
            end else begin
                i_ram_data_r <= ram_mem[o_ram_addr];
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0] ref_mem [1<<AW];
    logic [W-1:0] exp_q [$];      // read data the bus still owes, in order
    logic         m_inflight;     // read issued to the RAM, data not yet back
    logic [W-1:0] m_inflight_data;
    logic [W-1:0] got_q [$];      // responses actually taken by the master
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Outstanding reads (owed to the bus) limit how many more can be taken.
    function automatic logic model_accept(input vec_t v);
        int owed;
        owed = exp_q.size() + int'(m_inflight);
        return !v.dly && v.mrn &&
               ((v.cmd == CMD_WR) || ((v.cmd == CMD_RD) && (owed < DEPTH)));
    endfunction

    task automatic model_update(input vec_t v, input logic acc);
        int idx;
        idx = int'(v.addr[AW-1:0]);
        if (!v.mrn) begin
            exp_q.delete();
            m_inflight = 1'b0;
        end else begin
            if (exp_q.size() > 0 && v.racc) void'(exp_q.pop_front());
            if (m_inflight && !v.dly) begin
                exp_q.push_back(m_inflight_data);
                m_inflight = 1'b0;
            end
            if (acc && v.cmd == CMD_RD) begin
                m_inflight      = 1'b1;
                m_inflight_data = ref_mem[idx];
            end else if (acc && v.cmd == CMD_WR) begin
                for (int b = 0; b < 4; b++)
                    if (v.be[b]) ref_mem[idx][8*b +: 8] = v.data[8*b +: 8];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input vec_t v, input logic use_tab, output logic acc_seen);
        logic acc;
        @(negedge clk);
        i_m_cmd         = v.cmd;
        i_m_addr        = v.addr;
        i_m_data        = v.data;
        i_m_byte_en     = v.be;
        i_m_resp_accept = v.racc;
        i_ram_delay     = v.dly;
        i_m_reset_n     = v.mrn;
        #2;
        acc = model_accept(v);
        chk("accept", o_s_cmd_accept, acc);
        chk("ram_en", o_ram_en, acc);
        if (acc) begin
            chk("ram_we", o_ram_we, v.cmd == CMD_WR);
            chk("ram_addr", o_ram_addr, v.addr[AW-1:0]);
            if (v.cmd == CMD_WR) chk("ram_be", o_ram_be, v.be);
        end
        chk("resp", o_s_resp, exp_q.size() != 0 ? RESP_DVA : RESP_NULL);
        chk("data", o_s_data, exp_q.size() != 0 ? exp_q[0] : 32'h0);
        if (use_tab) begin
            chk("tab_accept", o_s_cmd_accept, v.exp_acc);
            chk("tab_resp", o_s_resp, v.exp_resp);
            chk("tab_data", o_s_data, v.exp_data);
        end
        acc_seen = o_s_cmd_accept;
        if (o_s_resp == RESP_DVA && v.racc) got_q.push_back(o_s_data);
        @(posedge clk);
        model_update(v, acc);
    endtask

    function automatic vec_t mk(input logic [1:0] cmd, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic racc, input logic dly, input logic eacc,
                                input logic [1:0] eresp, input logic [31:0] edata);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.data = data; v.be = be;
        v.racc = racc; v.dly = dly; v.mrn = 1'b1;
        v.exp_acc = eacc; v.exp_resp = eresp; v.exp_data = edata;
        return v;
    endfunction

    function automatic vec_t rd(input logic [31:0] addr, input logic racc);
        return mk(CMD_RD, addr, 32'h0, 4'h0, racc, 1'b0, 1'b0, RESP_NULL, 32'h0);
    endfunction

    function automatic vec_t idle(input logic racc);
        return mk(CMD_IDLE, 32'h0, 32'h0, 4'h0, racc, 1'b0, 1'b0, RESP_NULL, 32'h0);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t tab [$];
        vec_t v;
        logic a;
        int   n_acc;

        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = {16'hCAFE, 4'h0, i[11:0]};
            ref_mem[i] = {16'hCAFE, 4'h0, i[11:0]};
        end
        m_inflight      = 1'b0;
        m_inflight_data = '0;

        // Single read
        tab.push_back(mk(CMD_RD,   32'h010, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_0010));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        // Critical-word-first wrapping burst 2,3,0,1
        tab.push_back(mk(CMD_RD,   32'h012, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_RD,   32'h013, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_RD,   32'h010, 0, 0, 1, 0, 1, RESP_DVA,  32'hCAFE_0012));
        tab.push_back(mk(CMD_RD,   32'h011, 0, 0, 1, 0, 1, RESP_DVA,  32'hCAFE_0013));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_0010));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_0011));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        // Partial write then read-back, no response for the write
        tab.push_back(mk(CMD_WR,   32'h020, 32'h1234_5678, 4'b0011, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_RD,   32'h020, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_5678));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        // Upper address bits alias onto the same word
        tab.push_back(mk(CMD_RD,   32'hFFFF_F020, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_5678));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));
        // RAM delay of two cycles after a read
        tab.push_back(mk(CMD_RD,   32'h030, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_RD,   32'h031, 0, 0, 1, 1, 0, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_RD,   32'h031, 0, 0, 1, 1, 0, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_RD,   32'h031, 0, 0, 1, 0, 1, RESP_NULL, 32'h0));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_0030));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_DVA,  32'hCAFE_0031));
        tab.push_back(mk(CMD_IDLE, 32'h0,   0, 0, 1, 0, 0, RESP_NULL, 32'h0));

        // Reset state, with a write offered so accept gating is exercised
        reset = 1'b1;
        i_m_cmd = CMD_WR; i_m_addr = 32'h0; i_m_data = 32'h0; i_m_byte_en = 4'hF;
        i_m_resp_accept = 1'b1; i_m_reset_n = 1'b1; i_ram_delay = 1'b0;
        #12;
        chk("reset_accept", o_s_cmd_accept, 1'b0);
        chk("reset_resp", o_s_resp, RESP_NULL);
        chk("reset_data", o_s_data, 32'h0);
        chk("reset_ram_en", o_ram_en, 1'b0);
        chk("reset_ram_we", o_ram_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        i_m_cmd = CMD_IDLE;

        for (int i = 0; i < tab.size(); i++) drive_cycle(tab[i], 1'b1, a);

        // Backpressure: six reads offered with MRespAccept low
        got_q.delete();
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(rd(32'h040 + n_acc, 1'b0), 1'b0, a);
            if (a) n_acc++;
        end
        chk("bp_accepted_stalled", n_acc, 4);
        for (int c = 0; c < 30 && n_acc < 6; c++) begin
            drive_cycle(rd(32'h040 + n_acc, 1'b1), 1'b0, a);
            if (a) n_acc++;
        end
        chk("bp_accepted_total", n_acc, 6);
        for (int c = 0; c < 8; c++) drive_cycle(idle(1'b1), 1'b0, a);
        chk("bp_resp_count", got_q.size(), 6);
        for (int i = 0; i < got_q.size(); i++) chk("bp_order", got_q[i], 32'hCAFE_0040 + i);

        // Reset with two responses queued and one read in the RAM
        drive_cycle(rd(32'h050, 1'b0), 1'b0, a);
        drive_cycle(rd(32'h051, 1'b0), 1'b0, a);
        drive_cycle(rd(32'h052, 1'b0), 1'b0, a);
        @(negedge clk);
        i_m_cmd = CMD_RD; i_m_addr = 32'h060;
        reset = 1'b1;
        #2;
        chk("midrst_resp", o_s_resp, RESP_NULL);
        chk("midrst_data", o_s_data, 32'h0);
        chk("midrst_accept", o_s_cmd_accept, 1'b0);
        chk("midrst_ram_en", o_ram_en, 1'b0);
        exp_q.delete();
        m_inflight = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        i_m_cmd = CMD_IDLE;
        for (int c = 0; c < 4; c++) drive_cycle(idle(1'b1), 1'b0, a);
        for (int i = 0; i < 4; i++) drive_cycle(tab[i], 1'b1, a);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = $urandom_range(0, 9);
            v.cmd  = (sel < 4) ? CMD_RD : (sel < 6) ? CMD_WR : CMD_IDLE;
            v.addr = $urandom;
            v.addr[AW-1:0] = AW'($urandom_range(0, 63));
            v.data = $urandom;
            v.be   = 4'($urandom_range(0, 15));
            v.racc = ($urandom_range(0, 9) < 7);
            v.dly  = ($urandom_range(0, 9) < 2);
            v.mrn  = ($urandom_range(0, 49) != 0);
            v.exp_acc = 1'b0; v.exp_resp = RESP_NULL; v.exp_data = 32'h0;
            drive_cycle(v, 1'b0, a);
        end
        for (int c = 0; c < 8; c++) drive_cycle(idle(1'b1), 1'b0, a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_ram_responder.md
# bus_ram_responder

Bus slave that serves line-fetch and store traffic issued by the instruction/data read caches (e.g. critical-word-first wrapping bursts of single-word RD commands) out of a synchronous single-port RAM. It accepts one command per cycle on a Bus_if slave port, drives a Ram_if client port, and returns read data in order through a small response FIFO that absorbs MRespAccept backpressure. Writes are posted and produce no response.

## Interface
- RESP_DEPTH, 4: response FIFO entries, power of two, ≥2.
- MEM_ADDR_SIZE, 12: word-address bits forwarded to the RAM.
- WORD_SIZE, 32: data width; must match the Bus_if and Ram_if data widths.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- bus  Bus_if.slave  —  uses MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n (in); SCmdAccept, SResp, SData (out).
- ram  Ram_if.client  —  uses en, we, be, addr, data_w (out); data_r, delay (in).

## Operation
- Command accept, combinational: SCmdAccept = !ram.delay && MReset_n && ((MCmd==RD && occ < RESP_DEPTH) || MCmd==WR), where occ = FIFO count + pending (0/1). IDLE → SCmdAccept=0.
- Accepted RD: ram.en=1, we=0, be='1, addr=MAddr[MEM_ADDR_SIZE-1:0], all in the accept cycle. Sets pending.
- Accepted WR: ram.en=1, we=1, be=MByteEn, data_w=MData, same cycle. No pending, no response.
- Upper MAddr bits above MEM_ADDR_SIZE are ignored (aliasing). Addresses are word addresses.
- Capture: pending clears and ram.data_r is pushed into the FIFO in the first cycle after the RD cycle with ram.delay==0. Pending is held while ram.delay=1.
- Response: SResp=DVA and SData=FIFO head whenever the FIFO is non-empty. Otherwise SResp=NULL and SData='0. Pop on DVA && MRespAccept.
- Ordering: responses are strictly in RD-accept order. A WR accepted between reads does not reorder them.
- Occupancy: occ does not credit a same-cycle pop. The FIFO can therefore never overflow. Push and pop in the same cycle is legal and leaves the count unchanged.
- MReset_n==0: acts as a synchronous flush. FIFO emptied, pending cleared, SCmdAccept=0.
- reset: FIFO pointers and count → 0, pending → 0. Outputs: SCmdAccept=0, SResp=NULL, SData=0, ram.en=0, ram.we=0. An in-flight read is discarded, and no stale DVA appears after reset release.

## Timing
- RD latency: accept in cycle n → DVA in cycle n+2 (no RAM delay). Each RAM delay cycle adds one cycle.
- Throughput: one command per cycle with MRespAccept held 1. RESP_DEPTH=4 suffices for sustained full rate.
- With MRespAccept=0: at most RESP_DEPTH reads are accepted before SCmdAccept drops. After the first pop, SCmdAccept rises again in the following cycle.
- SResp/SData are registered (FIFO output). They are stable while DVA && !MRespAccept.
- ram.delay=1 forces SCmdAccept=0 in the same cycle.

## Structure
- The Bus package supplies the MCmd encodings (IDLE/RD/WR) and the SResp encodings (NULL/DVA). No new package types are needed.
- Sub-module resp_fifo: parameters DEPTH and WIDTH; ports push/pop/data_in/data_out/count/empty; asynchronous reset plus synchronous flush.
- Top level: accept logic, pending flag, RAM drive, response mux.

## Test plan
- Single RD to 0x010 holding 0xCAFE_0010, MRespAccept=1 → ram.en at cycle 0, DVA with SData=0xCAFE_0010 at cycle 2, one response only.
- 4-word wrapping burst at displacements 2,3,0,1 on back-to-back cycles → SCmdAccept=1 every cycle, 4 DVAs in consecutive cycles in the same order.
- MRespAccept=0, 6 RDs offered:
  - Exactly 4 accepted, then SCmdAccept=0 and SResp=DVA stable on the first datum.
  - Raise MRespAccept → remaining 2 accepted, all 6 returned in order.
- WR 0x020 = 0x1234_5678 with MByteEn=4'b0011, then RD 0x020 → no response for the WR; RD returns the old upper half merged with 0x5678 in the lower half.
- ram.delay=1 for 2 cycles after an RD → SCmdAccept=0 during the delay, DVA arrives at cycle 4, data correct.
- reset asserted with 2 responses queued and 1 pending → SResp=NULL immediately, no DVA after release; the next RD behaves as in the first scenario.
